// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, redirect input and decode-side handshake.
// The master side is the fetch unit itself.
interface instruction_fetch_unit_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            fetch_en;
  logic [31:0]     imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [31:0]     redirect_target;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [31:0]     id_pc;
  logic [31:0]     id_pc4;
  logic [CntW-1:0] fetch_count;

  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_target, id_ready,
    output imem_addr, id_valid, id_instr, id_pc, id_pc4, fetch_count
  );

  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_target, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc, id_pc4, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches from instruction memory into an in-order
// queue of {pc, instr} entries and hands them to decode; redirects flush the queue.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                         clk,
  input logic                         reset,
  instruction_fetch_unit_if.master    bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     mem_q [DEPTH];
  logic [63:0]     head;
  logic            id_valid;
  logic            pop;
  logic            push;
  logic            unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^bus.redirect_target[1:0];

  assign id_valid = (count_q != '0);
  assign pop      = id_valid & bus.id_ready;
  assign push     = bus.fetch_en & ~bus.redirect_valid & ((count_q < CntW'(DEPTH)) | pop);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      // Redirect wins: flush the queue; a same-cycle pop is simply discarded with it.
      fetch_pc_d = {bus.redirect_target[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fetch_pc_q, bus.imem_rdata};
    end
  end

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.id_valid    = id_valid;
  assign bus.id_pc       = id_valid ? head[63:32] : 32'h0;
  assign bus.id_instr    = id_valid ? head[31:0] : 32'h0;
  assign bus.id_pc4      = id_valid ? (head[63:32] + 32'd4) : 32'h0;
  assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stream, backpressure, full+pop, redirect,
// PC wrap, drain with fetch disabled and asynchronous reset mid-run.
module tb_instruction_fetch_unit;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  instruction_fetch_unit_if #(.DEPTH(4)) bus ();

  instruction_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: combinational, pattern derived from the address.
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.fetch_en = 1'b0;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    tick();
    tick();
    total_cnt++;
    if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h required %h", bus.imem_addr, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.id_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", bus.id_valid);
    else pass_cnt++;
    total_cnt++;
    if ({bus.id_instr, bus.id_pc, bus.id_pc4} !== 96'h0)
      $display("FAIL reset_id: got %h %h %h required 0 0 0", bus.id_instr, bus.id_pc, bus.id_pc4);
    else pass_cnt++;
    total_cnt++;
    if (bus.fetch_count !== 3'd0) $display("FAIL reset_count: got %0d required 0", bus.fetch_count);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    reset = 1'b1;
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      pc = 32'(i) * 32'd4;
      total_cnt++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== pc || bus.id_pc4 !== pc + 32'd4 ||
          bus.id_instr !== (pc ^ 32'hA5A5_0000))
        $display("FAIL stream[%0d]: got v=%b pc=%h pc4=%h instr=%h required v=1 pc=%h pc4=%h instr=%h",
                 i, bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_instr, pc, pc + 32'd4,
                 pc ^ 32'hA5A5_0000);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int k;
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      k = (i < 4) ? i : 4;
      total_cnt++;
      if (bus.fetch_count !== 3'(k) || bus.imem_addr !== 32'(k * 4) || bus.id_pc !== 32'h0 ||
          bus.id_valid !== 1'b1)
        $display("FAIL backpressure[%0d]: got cnt=%0d addr=%h pc=%h v=%b required cnt=%0d addr=%h pc=0 v=1",
                 i, bus.fetch_count, bus.imem_addr, bus.id_pc, bus.id_valid, k, k * 4);
      else pass_cnt++;
    end
  endtask

  // Continues from a full queue: drains 0,4,8,C,10,... while refilling at one per cycle.
  task automatic test_full_pop();
    bus.id_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      total_cnt++;
      if (bus.id_pc !== 32'(4 * j) || bus.fetch_count !== 3'd4 ||
          bus.imem_addr !== 32'h10 + 32'(4 * j))
        $display("FAIL full_pop[%0d]: got pc=%h cnt=%0d addr=%h required pc=%h cnt=4 addr=%h",
                 j, bus.id_pc, bus.fetch_count, bus.imem_addr, 4 * j, 32'h10 + 32'(4 * j));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    bus.fetch_en = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    total_cnt++;
    if (bus.fetch_count !== 3'd3) $display("FAIL redir_setup: got %0d required 3", bus.fetch_count);
    else pass_cnt++;
    bus.fetch_en = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    tick();
    bus.redirect_valid = 1'b0;
    total_cnt++;
    if (bus.fetch_count !== 3'd0 || bus.imem_addr !== 32'h100 || bus.id_valid !== 1'b0 ||
        bus.id_pc !== 32'h0)
      $display("FAIL redir_flush: got cnt=%0d addr=%h v=%b pc=%h required cnt=0 addr=00000100 v=0 pc=0",
               bus.fetch_count, bus.imem_addr, bus.id_valid, bus.id_pc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_instr !== 32'hA5A5_0100)
      $display("FAIL redir_first: got v=%b pc=%h instr=%h required v=1 pc=00000100 instr=a5a50100",
               bus.id_valid, bus.id_pc, bus.id_instr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.id_pc !== 32'h104) $display("FAIL redir_second: got %h required 00000104", bus.id_pc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_pc4 [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc4[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'hFFFF_FFFC; exp_pc4[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0000; exp_pc4[2] = 32'h0000_0004;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    total_cnt++;
    if (bus.imem_addr !== 32'hFFFF_FFF8 || bus.id_valid !== 1'b0)
      $display("FAIL wrap_redir: got addr=%h v=%b required addr=fffffff8 v=0", bus.imem_addr, bus.id_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc[i] || bus.id_pc4 !== exp_pc4[i])
        $display("FAIL wrap[%0d]: got v=%b pc=%h pc4=%h required v=1 pc=%h pc4=%h",
                 i, bus.id_valid, bus.id_pc, bus.id_pc4, exp_pc[i], exp_pc4[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_drain_and_reset();
    // Head is PC 0 with fetch_pc at 4; fill to four entries (0,4,8,C).
    bus.id_ready = 1'b0;
    bus.fetch_en = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if (bus.fetch_count !== 3'd4 || bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h10)
      $display("FAIL drain_fill: got cnt=%0d pc=%h addr=%h required cnt=4 pc=0 addr=00000010",
               bus.fetch_count, bus.id_pc, bus.imem_addr);
    else pass_cnt++;
    bus.fetch_en = 1'b0;
    bus.id_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      total_cnt++;
      if (bus.fetch_count !== 3'(4 - j) || bus.imem_addr !== 32'h10 ||
          bus.id_pc !== ((j < 4) ? 32'(4 * j) : 32'h0) || bus.id_valid !== (j < 4))
        $display("FAIL drain[%0d]: got cnt=%0d addr=%h pc=%h v=%b required cnt=%0d addr=00000010 pc=%h v=%b",
                 j, bus.fetch_count, bus.imem_addr, bus.id_pc, bus.id_valid, 4 - j,
                 (j < 4) ? 32'(4 * j) : 32'h0, j < 4);
      else pass_cnt++;
    end
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b0;
    tick(); tick();
    total_cnt++;
    if (bus.fetch_count !== 3'd2 || bus.imem_addr !== 32'h18)
      $display("FAIL refill: got cnt=%0d addr=%h required cnt=2 addr=00000018",
               bus.fetch_count, bus.imem_addr);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.fetch_count !== 3'd0 ||
        bus.id_pc !== 32'h0)
      $display("FAIL async_reset: got v=%b addr=%h cnt=%0d pc=%h required v=0 addr=0 cnt=0 pc=0",
               bus.id_valid, bus.imem_addr, bus.fetch_count, bus.id_pc);
    else pass_cnt++;
    tick();
    reset = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    total_cnt++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h4)
      $display("FAIL restart: got v=%b pc=%h addr=%h required v=1 pc=0 addr=00000004",
               bus.id_valid, bus.id_pc, bus.imem_addr);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_redirect();
    test_wrap();
    test_drain_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end stage of the single-cycle CPU: owns the program counter, drives the instruction memory address, and buffers fetched words in a small in-order queue. Delivers each instruction with its PC to the decode / main control unit through a valid/ready handshake. Accepts branch/jump redirects from execute, which flush the queue. Replaces the bare PC register as the producer of the instruction word consumed by decode and register-file read.

## Interface
- DEPTH, 4: fetch queue entries; must be a power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch address after reset; must be word-aligned.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately on assertion.
- fetch_en  input  1  1 = fetch allowed this cycle; 0 = hold fetch_pc, enqueue nothing.
- imem_addr  output  32  word-aligned fetch address; always equals fetch_pc.
- imem_rdata  input  32  instruction at imem_addr, combinational, same cycle.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_target  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
- id_valid  output  1  head entry present.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_instr  output  32  head instruction; 0 when the queue is empty.
- id_pc  output  32  head PC; 0 when the queue is empty.
- id_pc4  output  32  id_pc + 4, mod 2^32; 0 when the queue is empty.
- fetch_count  output  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- State: fetch_pc (32b), DEPTH x 64b entries {pc, instr}, rd_ptr and wr_ptr ($clog2(DEPTH) bits, wrap naturally), count.
- pop = id_valid & id_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
- On push: the entry at wr_ptr gets {fetch_pc, imem_rdata}. wr_ptr increments. fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- On pop: rd_ptr increments.
- count update: count + push - pop.
- Full with a simultaneous pop: the push is accepted, and count stays at DEPTH.
- Empty: a pop cannot occur because id_valid = 0. A push goes into the queue; there is no bypass to the outputs.
- Redirect has priority over everything:
  - count, rd_ptr and wr_ptr go to 0.
  - fetch_pc <= {redirect_target[31:2], 2'b00}.
  - No push occurs that cycle.
  - A pop handshake in the same cycle still counts as consumed by decode. The queue is flushed regardless.
- fetch_en = 0: fetch_pc is held and no push occurs. Pops continue, so the queue drains.
- id_valid = (count != 0). id_instr, id_pc and id_pc4 come from the entry at rd_ptr, and are forced to 0 when count == 0.
- Reset: fetch_pc = RESET_PC, count = 0, both pointers = 0, so id_valid = 0 and fetch_count = 0. Queue storage need not be cleared.

## Timing
- Reset values, held while reset = 0:
  - imem_addr = RESET_PC.
  - id_valid, id_instr, id_pc, id_pc4 and fetch_count all = 0.
- Reset released mid-stream: fetching restarts at RESET_PC. Anything in flight before the assertion is lost.
- Fetch-to-decode latency is 1 cycle. A word pushed at edge N is visible at id_* after edge N and can be popped in the following cycle.
- Redirect to first new instruction:
  - redirect_valid high in cycle N.
  - imem_addr = target from cycle N+1.
  - id_valid first returns high in cycle N+2 (if fetch_en = 1).
- Sustained throughput is 1 instruction/cycle when id_ready = 1 and fetch_en = 1.
- The id_* outputs are stable while id_valid = 1 and id_ready = 0, unless a redirect occurs.
- imem_addr changes only at clock edges or on reset assertion.

## Test plan
- Reset then stream: RESET_PC = 0, imem returns addr ^ 32'hA5A5_0000, id_ready = 1.
  - Required: id_valid rises 1 cycle after reset release.
  - id_pc sequence is 0, 4, 8, ...; id_pc4 = id_pc + 4; id_instr matches the pattern.
  - One instruction per cycle, with no gaps.
- Backpressure: id_ready = 0 for 8 cycles.
  - Required: fetch_count climbs to 4 and stays there; imem_addr holds at 0x10.
  - id_pc holds at 0 throughout.
  - When id_ready returns to 1, PCs 0, 4, 8, 0xC, 0x10 drain in order with no loss or duplication.
- Full with simultaneous pop: queue full and id_ready = 1 with fetch_en = 1.
  - Required: count stays at 4, one push and one pop per cycle, ordering preserved.
- Redirect with a non-empty queue: count = 3, then a redirect_valid pulse with target 32'h0000_0103.
  - Required: count = 0 next cycle; imem_addr = 0x100.
  - Two cycles later, id_valid = 1 with id_pc = 0x100.
  - No stale PC ever appears at id_pc after the redirect.
- PC wrap: redirect to 32'hFFFF_FFF8.
  - Required: id_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - id_pc4 for FFFF_FFFC is 0.
- fetch_en low plus async reset mid-run:
  - fetch_en = 0 drains the queue while imem_addr holds.
  - Asserting reset between clock edges immediately drives id_valid = 0 and imem_addr = RESET_PC.
